// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and commit modes.
package md_unit_pkg;

    localparam logic [3:0] MDUOP_MULT  = 4'd0;
    localparam logic [3:0] MDUOP_MULTU = 4'd1;
    localparam logic [3:0] MDUOP_DIV   = 4'd2;
    localparam logic [3:0] MDUOP_DIVU  = 4'd3;
    localparam logic [3:0] MDUOP_MTHI  = 4'd4;
    localparam logic [3:0] MDUOP_MTLO  = 4'd5;
    localparam logic [3:0] MDUOP_MADD  = 4'd6;
    localparam logic [3:0] MDUOP_MADDU = 4'd7;
    localparam logic [3:0] MDUOP_MSUB  = 4'd8;
    localparam logic [3:0] MDUOP_MSUBU = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // What the final RUN edge does with the pending result.
    typedef enum logic [1:0] {
        CM_NONE = 2'd0,
        CM_SET  = 2'd1,
        CM_ADD  = 2'd2,
        CM_SUB  = 2'd3
    } commit_e;

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MDUOP_MULT) || (op == MDUOP_DIV) ||
               (op == MDUOP_MADD) || (op == MDUOP_MSUB);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational product, quotient and remainder; signedness is taken from op.
module md_arith
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;

    always_comb begin
        sgn   = is_signed_op(op);
        a_neg = sgn & operand1[WIDTH-1];
        b_neg = sgn & operand2[WIDTH-1];

        // Sign-extended operands give the correct signed product modulo 2^(2*WIDTH).
        a_ext   = {{WIDTH{a_neg}}, operand1};
        b_ext   = {{WIDTH{b_neg}}, operand2};
        product = a_ext * b_ext;

        // Divide on magnitudes, then restore signs; MIN / -1 wraps back to MIN with remainder 0.
        a_mag       = a_neg ? (~operand1 + WIDTH'(1)) : operand1;
        b_mag       = b_neg ? (~operand2 + WIDTH'(1)) : operand2;
        div_by_zero = (operand2 == '0);
        b_safe      = div_by_zero ? WIDTH'(1) : b_mag;
        q_mag       = a_mag / b_safe;
        r_mag       = a_mag % b_safe;
        quotient    = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
        remainder   = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and busy for hazard stalls.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by MDU_MADD_EN.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 5,
    parameter int DIV_LATENCY = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             read_sel,
    output logic             busy,
    output logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

    md_state_e          state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    commit_e            commit_q, commit_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               div_by_zero;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op          (op),
        .operand1    (operand1),
        .operand2    (operand2),
        .product     (product),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

`ifdef MDU_MADD_EN
    // Accumulation uses HI/LO as they stand at the commit edge.
    logic [2*WIDTH-1:0] acc_add;
    logic [2*WIDTH-1:0] acc_sub;
    assign acc_add = {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
    assign acc_sub = {hi_q, lo_q} - {pend_hi_q, pend_lo_q};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        commit_d  = commit_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDUOP_MULT, MDUOP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = product;
                            commit_d = CM_SET;
                            cnt_d    = MUL_CNT;
                            state_d  = ST_RUN;
                        end
`ifdef MDU_MADD_EN
                        MDUOP_MADD, MDUOP_MADDU: begin
                            {pend_hi_d, pend_lo_d} = product;
                            commit_d = CM_ADD;
                            cnt_d    = MUL_CNT;
                            state_d  = ST_RUN;
                        end
                        MDUOP_MSUB, MDUOP_MSUBU: begin
                            {pend_hi_d, pend_lo_d} = product;
                            commit_d = CM_SUB;
                            cnt_d    = MUL_CNT;
                            state_d  = ST_RUN;
                        end
`endif
                        MDUOP_DIV, MDUOP_DIVU: begin
                            pend_lo_d = quotient;
                            pend_hi_d = remainder;
                            commit_d  = div_by_zero ? CM_NONE : CM_SET;
                            cnt_d     = DIV_CNT;
                            state_d   = ST_RUN;
                        end
                        MDUOP_MTHI: hi_d = operand1;
                        MDUOP_MTLO: lo_d = operand1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    state_d = ST_IDLE;
                    case (commit_q)
                        CM_SET: begin
                            hi_d = pend_hi_q;
                            lo_d = pend_lo_q;
                        end
`ifdef MDU_MADD_EN
                        CM_ADD: {hi_d, lo_d} = acc_add;
                        CM_SUB: {hi_d, lo_d} = acc_sub;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            commit_q  <= CM_NONE;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            commit_q  <= commit_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign read_data = read_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: behavioural HI/LO model plus directed literal checks.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        read_sel = 1'b0;
    logic        busy;
    logic [31:0] read_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    bit checking_on = 1'b0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MUL_LATENCY(5), .DIV_LATENCY(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand1  (operand1),
        .operand2  (operand2),
        .read_sel  (read_sel),
        .busy      (busy),
        .read_data (read_data),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: remaining cycles, a pending 64-bit result and how it lands.
    int          m_rem = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;
    int          m_kind = 0;  // 0 none, 1 set, 2 add, 3 sub

    function automatic logic [63:0] mul64(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        if (b == 0) begin
            m_kind = 0;
        end else if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_pend = {r[31:0], q[31:0]};
            m_kind = 1;
        end else begin
            m_pend = {a % b, a / b};
            m_kind = 1;
        end
        m_rem = 10;
    endtask

    always @(posedge reset) begin
        m_rem = 0; m_hi = '0; m_lo = '0; m_kind = 0;
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    case (m_kind)
                        1: {m_hi, m_lo} = m_pend;
                        2: {m_hi, m_lo} = {m_hi, m_lo} + m_pend;
                        3: {m_hi, m_lo} = {m_hi, m_lo} - m_pend;
                        default: ;
                    endcase
                end
            end else if (start) begin
                case (op)
                    MDUOP_MULT:  begin m_pend = mul64(1, operand1, operand2); m_kind = 1; m_rem = 5; end
                    MDUOP_MULTU: begin m_pend = mul64(0, operand1, operand2); m_kind = 1; m_rem = 5; end
`ifdef MDU_MADD_EN
                    MDUOP_MADD:  begin m_pend = mul64(1, operand1, operand2); m_kind = 2; m_rem = 5; end
                    MDUOP_MADDU: begin m_pend = mul64(0, operand1, operand2); m_kind = 2; m_rem = 5; end
                    MDUOP_MSUB:  begin m_pend = mul64(1, operand1, operand2); m_kind = 3; m_rem = 5; end
                    MDUOP_MSUBU: begin m_pend = mul64(0, operand1, operand2); m_kind = 3; m_rem = 5; end
`endif
                    MDUOP_DIV:   model_div(1, operand1, operand2);
                    MDUOP_DIVU:  model_div(0, operand1, operand2);
                    MDUOP_MTHI:  m_hi = operand1;
                    MDUOP_MTLO:  m_lo = operand1;
                    default: ;
                endcase
            end
        end
    end

    // Compare process: every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (checking_on && !reset) begin
            check("busy", busy, m_rem != 0);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("read_data", read_data, read_sel ? m_hi : m_lo);
        end
    end

    always @(negedge clk) read_sel = ~read_sel;

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(o, a, b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        #2 reset = 1'b1;
        #10 reset = 1'b0;
        @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", busy, 1'b0);
        checking_on = 1'b1;

        issue(MDUOP_MULT, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        check("mult_busy_cycles", n, 5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        issue(MDUOP_MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(MDUOP_DIV, 32'hFFFF_FFF9, 32'h2);
        wait_idle(n);
        check("div_busy_cycles", n, 10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(MDUOP_DIVU, 32'h7, 32'h2);
        wait_idle(n);
        check("divu_lo", lo, 32'h3);
        check("divu_hi", hi, 32'h1);

        issue(MDUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        issue(MDUOP_MTHI, 32'h11, 32'h0);
        issue(MDUOP_MTLO, 32'h22, 32'h0);
        issue(MDUOP_DIV, 32'h5, 32'h0);
        wait_idle(n);
        check("div0_busy_cycles", n, 10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        // Requests during busy are dropped.
        issue(MDUOP_MULT, 32'h3, 32'h4);
        drive(MDUOP_MTLO, 32'hABCD, 32'h0);
        @(negedge clk);
        drive(MDUOP_MULT, 32'h5, 32'h5);
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        check("ignored_hi", hi, 32'h0);
        check("ignored_lo", lo, 32'hC);

        issue(MDUOP_MTLO, 32'hABCD, 32'h0);
        check("mtlo_lo", lo, 32'hABCD);
        check("mtlo_busy", busy, 1'b0);
        @(negedge clk);
        check("mtlo_busy_after", busy, 1'b0);

        // Start in the commit cycle is ignored; the next cycle it is accepted.
        issue(MDUOP_MULT, 32'h2, 32'h3);
        repeat (4) @(negedge clk);
        drive(MDUOP_MTHI, 32'h77, 32'h0);
        @(negedge clk);
        drive(MDUOP_MTHI, 32'h55, 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("commit_edge_hi", hi, 32'h55);
        check("commit_edge_lo", lo, 32'h6);

        // Asynchronous reset between edges during a divide.
        issue(MDUOP_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_busy", busy, 1'b0);
        check("async_hi", hi, 32'h0);
        check("async_lo", lo, 32'h0);
        #1 reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_hi", hi, 32'h0);
        check("post_reset_lo", lo, 32'h0);

        issue(MDUOP_MTHI, 32'h0, 32'h0);
        issue(MDUOP_MTLO, 32'hFFFF_FFFF, 32'h0);
        issue(MDUOP_MADDU, 32'h1, 32'h1);
`ifdef MDU_MADD_EN
        wait_idle(n);
        check("maddu_busy_cycles", n, 5);
        check("maddu_hi", hi, 32'h1);
        check("maddu_lo", lo, 32'h0);
`else
        check("maddu_off_busy", busy, 1'b0);
        repeat (7) @(negedge clk);
        check("maddu_off_hi", hi, 32'h0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
